// File: rtl/hazard_sequencer_if.sv
// Pipeline-control bundle between the hazard sequencer and the F/D/E/M/W datapath.
// master = datapath side, slave = hazard_sequencer.
interface hazard_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned REG_W = 5;

    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic             e_memread;
    logic             e_regwrite;
    logic [REG_W-1:0] e_dst;
    logic             m_regwrite;
    logic [REG_W-1:0] m_dst;
    logic             pc_src;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output d_rs, d_rt, d_use_rs, d_use_rt, e_memread, e_regwrite, e_dst,
               m_regwrite, m_dst, pc_src,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_use_rs, d_use_rt, e_memread, e_regwrite, e_dst,
               m_regwrite, m_dst, pc_src,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use stall sequencing, branch flush control and registered E-stage forwarding selects
// for the 5-stage pipeline, with saturating stall/flush event counters.
module hazard_sequencer #(
    parameter int unsigned LU_STALL = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_sequencer_if.slave bus
);
    localparam int unsigned SCNT_W = 2;
    localparam int unsigned REG_W  = 5;
    localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(LU_STALL - 1);

    typedef enum logic {RUN, STALL} state_t;

    state_t            state;
    logic [SCNT_W-1:0] scnt;
    logic              lu_hit;
    logic              hazard;

    function automatic logic [1:0] fwd_sel(input logic             e_rw,
                                           input logic [REG_W-1:0] e_d,
                                           input logic             m_rw,
                                           input logic [REG_W-1:0] m_d,
                                           input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_rw && (e_d != '0) && (e_d == src))
            sel = 2'b10;
        else if (m_rw && (m_d != '0) && (m_d == src))
            sel = 2'b01;
        return sel;
    endfunction

    assign lu_hit = bus.e_memread && bus.e_regwrite && (bus.e_dst != '0) &&
                    ((bus.d_use_rs && (bus.d_rs == bus.e_dst)) ||
                     (bus.d_use_rt && (bus.d_rt == bus.e_dst)));

    // Branch flush beats the stall; reset forces the free-running pipeline controls.
    always_comb begin
        hazard           = 1'b0;
        bus.pc_en        = 1'b1;
        bus.ifid_en      = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.exmem_flush  = 1'b0;
        if (!rst) begin
            if (bus.pc_src) begin
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
            end else if ((state == STALL) || lu_hit) begin
                hazard         = 1'b1;
                bus.pc_en      = 1'b0;
                bus.ifid_en    = 1'b0;
                bus.idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            scnt          <= '0;
            bus.fwd_a     <= 2'b00;
            bus.fwd_b     <= 2'b00;
            bus.stall_cnt <= '0;
            bus.flush_cnt <= '0;
        end else begin
            if (bus.pc_src) begin
                state <= RUN;
                scnt  <= '0;
                if (bus.flush_cnt != '1)
                    bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
            end else if (hazard) begin
                if (bus.stall_cnt != '1)
                    bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
                if (state == STALL) begin
                    scnt <= scnt - SCNT_W'(1);
                    if (scnt == SCNT_W'(1))
                        state <= RUN;
                end else if (LU_STALL > 1) begin
                    state <= STALL;
                    scnt  <= SCNT_INIT;
                end
            end

            // Selects travel with the instruction moving D->E; a bubble carries no forwarding.
            if (bus.idex_flush) begin
                bus.fwd_a <= 2'b00;
                bus.fwd_b <= 2'b00;
            end else begin
                bus.fwd_a <= fwd_sel(bus.e_regwrite, bus.e_dst, bus.m_regwrite, bus.m_dst, bus.d_rs);
                bus.fwd_b <= fwd_sel(bus.e_regwrite, bus.e_dst, bus.m_regwrite, bus.m_dst, bus.d_rt);
            end
        end
    end
endmodule
